// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and constants.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam int         PS2_DATA_BITS = 8;
endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus deglitch: the output follows the line only after
// FILT_LEN consecutive synchronized samples that disagree with it. Idles high.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 2'b11;
            cnt  <= '0;
            dout <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            // a binary line that differs from dout means every counted sample was equal
            if (sync[1] == dout)
                cnt <= '0;
            else if (cnt == CW'(FILT_LEN - 1)) begin
                dout <= sync[1];
                cnt  <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host frame receiver producing 8-bit scan codes.
// Optional PS2_BREAK_FILTER_EN suppresses F0/E0 and the byte following F0.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic       kclk, kdat, kclk_q, fall, timeout;
    ps2_state_t state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       par, par_n;
    logic       ok_n, show_n, perr_n, ferr_n;
    logic [TW-1:0] to_cnt;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (.clk(clk), .reset(reset), .din(ps2_clk),  .dout(kclk));
    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (.clk(clk), .reset(reset), .din(ps2_data), .dout(kdat));

    assign fall    = kclk_q & ~kclk;
    assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));

`ifdef PS2_BREAK_FILTER_EN
    logic brk, brk_n;
`endif

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        par_n     = par;
        ok_n      = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        // timeout takes priority over a coincident fall event
        if (timeout) begin
            state_n = IDLE;
            shift_n = '0;
            ferr_n  = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: if (!kdat) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    shift_n   = '0;
                end
                DATA: begin
                    shift_n[bit_cnt] = kdat;
                    bit_cnt_n        = bit_cnt + 1'b1;
                    if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = kdat;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!kdat)                 ferr_n = 1'b1;
                    else if (!(^{shift, par})) perr_n = 1'b1;
                    else                       ok_n   = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
        show_n = ok_n;
`ifdef PS2_BREAK_FILTER_EN
        brk_n = brk;
        if (perr_n || ferr_n)
            brk_n = 1'b0;
        else if (ok_n) begin
            if (shift == PS2_BREAK) begin
                brk_n  = 1'b1;
                show_n = 1'b0;
            end else if (shift == PS2_EXT)
                show_n = 1'b0;
            else if (brk) begin
                brk_n  = 1'b0;
                show_n = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            kclk_q     <= 1'b1;
            code       <= 8'h00;
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bit_cnt    <= bit_cnt_n;
            par        <= par_n;
            kclk_q     <= kclk;
            code_valid <= show_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            if (show_n) code <= shift;
            if (state == IDLE || fall) to_cnt <= '0;
            else if (!timeout)         to_cnt <= to_cnt + 1'b1;
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) brk <= 1'b0;
        else       brk <= brk_n;
    end
`endif
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Randomized and directed bench for ps2_scan_rx against a frame-level model.
module tb_ps2_scan_rx;
    localparam int FL = 4;
    localparam int TO = 2000;

    logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid, parity_err, frame_err;

    always #5 clk = ~clk;

    ps2_scan_rx #(.FILT_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code(code), .code_valid(code_valid), .parity_err(parity_err), .frame_err(frame_err)
    );

    typedef struct { int kind; logic [7:0] code; } exp_t;  // kind: 0 valid, 1 parity, 2 frame
    exp_t       q[$];
    int         n_chk = 0, n_pass = 0, n_valid = 0;
    logic [7:0] model_code = 8'h00;
    bit         brk_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Every cycle: each pulse must match the next expected frame outcome; code must hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (reset) model_code = 8'h00;
        else begin
            if (code_valid || parity_err || frame_err) begin
                chk("pulse_onehot", 32'(code_valid) + 32'(parity_err) + 32'(frame_err), 1);
                k = code_valid ? 0 : (parity_err ? 1 : 2);
                if (q.size() == 0) chk("unexpected_pulse", 32'({code_valid, parity_err, frame_err}), 0);
                else begin
                    e = q.pop_front();
                    chk("pulse_kind", k, e.kind);
                    if (code_valid) begin
                        model_code = e.code;
                        n_valid++;
                    end
                end
            end
            chk("code", code, model_code);
        end
    end

    task automatic expect_frame(input logic [7:0] b, input int kind);
        exp_t e;
        e.kind = kind;
        e.code = b;
        if (kind != 0) begin
            brk_m = 1'b0;
            q.push_back(e);
        end else begin
`ifdef PS2_BREAK_FILTER_EN
            if (b == 8'hF0)      brk_m = 1'b1;
            else if (b == 8'hE0) ;
            else if (brk_m)      brk_m = 1'b0;
            else                 q.push_back(e);
`else
            q.push_back(e);
`endif
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first n bits of an 11-bit frame (bit 0 = start), optional short clock glitches.
    task automatic send_bits(input logic [10:0] bits, input int n, input int hp, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (glitch) begin
                cyc(hp / 2);
                ps2_clk = 1'b0;
                cyc(FL - 2);
                ps2_clk = 1'b1;
                cyc(hp - hp / 2 - (FL - 2));
            end else cyc(hp);
            ps2_clk = 1'b0;
            cyc(hp);
            ps2_clk = 1'b1;
        end
        cyc(hp);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int kind, input int hp, input bit glitch);
        logic [10:0] bits;
        bits = {(kind == 2) ? 1'b0 : 1'b1, (~^b) ^ (kind == 1), b, 1'b0};
        expect_frame(b, kind);
        send_bits(bits, 11, hp, glitch);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 400) begin
            cyc(1);
            t++;
        end
        chk("drain", q.size(), 0);
        cyc(5);
    endtask

    initial begin
        int v0, kind, r;
        logic [7:0] b;
        logic [10:0] bits;
        cyc(3);
        @(negedge clk);
        chk("rst_code", code, 8'h00);
        chk("rst_pulses", 32'({code_valid, parity_err, frame_err}), 0);
        #1 reset = 1'b0;
        cyc(20);

        v0 = n_valid;
        send_frame(8'h1C, 0, 40, 1'b0); drain();
        chk("t1_code", code, 8'h1C);
        chk("t1_npulse", n_valid - v0, 1);

        v0 = n_valid;
        send_frame(8'h24, 1, 40, 1'b0); drain();
        chk("t2_code_kept", code, 8'h1C);
        chk("t2_npulse", n_valid - v0, 0);

        send_frame(8'h2D, 2, 40, 1'b0); drain();
        chk("t3_code_kept", code, 8'h1C);
        send_frame(8'h1B, 0, 40, 1'b0); drain();
        chk("t3_code", code, 8'h1B);

        bits = {1'b1, ~^8'h55, 8'h55, 1'b0};
        q.push_back('{2, 8'h00}); brk_m = 1'b0;
        send_bits(bits, 5, 40, 1'b0);
        cyc(TO + 50);
        chk("t4_timeout", q.size(), 0);
        send_frame(8'h23, 0, 40, 1'b0); drain();
        chk("t4_code", code, 8'h23);

        send_frame(8'h2B, 0, 40, 1'b1); drain();
        chk("t5_code", code, 8'h2B);

        v0 = n_valid;
        send_frame(8'h1D, 0, 40, 1'b0);
        send_frame(8'hF0, 0, 40, 1'b0);
        send_frame(8'h1D, 0, 40, 1'b0); drain();
        chk("t6_code", code, 8'h1D);
`ifdef PS2_BREAK_FILTER_EN
        chk("t6_npulse", n_valid - v0, 1);
`else
        chk("t6_npulse", n_valid - v0, 3);
`endif

        bits = {1'b1, ~^8'h3C, 8'h3C, 1'b0};
        send_bits(bits, 4, 40, 1'b0);
        reset = 1'b1;
        q.delete();
        brk_m = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(FL + 20);
        chk("t6_reset_code", code, 8'h00);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            kind = (r < 7) ? 0 : (r == 7 ? 1 : 2);
            b = 8'($urandom);
            if ($urandom_range(0, 5) == 0) b = 8'hF0;
            else if ($urandom_range(0, 9) == 0) b = 8'hE0;
            send_frame(b, kind, $urandom_range(20, 45), 1'($urandom_range(0, 1)));
            cyc($urandom_range(0, 30));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
